// File: rtl/reg_fetch_block_pkg.sv
// Shared processor constants used by the register-fetch stage and its scoreboard.
package reg_fetch_block_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned REG_AW = 3;
   localparam int unsigned NREG   = 8;
   localparam logic [REG_AW-1:0] REG_ZERO = 3'd0;

endpackage

// File: rtl/reg_fetch_block_scoreboard.sv
// Per-register busy tracking for in-flight destination writes, with hazard detection.
module reg_scoreboard #(
   parameter int unsigned NREG = reg_fetch_block_pkg::NREG
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       set_en_i,
   input  logic [2:0] set_addr_i,
   input  logic       clr_en_i,
   input  logic [2:0] clr_addr_i,
   input  logic       chk_valid_i,
   input  logic [2:0] rs_addr_i,
   input  logic [2:0] rt_addr_i,
   input  logic [2:0] rd_addr_i,
   input  logic       rd_write_i,
   output logic       hazard_o
);
   import reg_fetch_block_pkg::*;

   logic [NREG-1:0] busy_q, busy_d;
   logic [NREG-1:0] set_mask, clr_mask, pend;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en_i && set_addr_i != REG_ZERO) set_mask[set_addr_i] = 1'b1;
      if (clr_en_i) clr_mask[clr_addr_i] = 1'b1;
   end

   // A register being written back this cycle is no longer a hazard;
   // a simultaneous set is OR-ed in after the clear so it wins.
   assign pend   = busy_q & ~clr_mask;
   assign busy_d = pend | set_mask;

   assign hazard_o = chk_valid_i &
                     (pend[rs_addr_i] | pend[rt_addr_i] | (rd_write_i & pend[rd_addr_i]));

   always_ff @(posedge clk) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

endmodule

// File: rtl/reg_fetch_block.sv
// Register file with write-back bypass feeding a one-entry operand bundle register.
module reg_fetch_block #(
   parameter int unsigned DATA_W = reg_fetch_block_pkg::DATA_W,
   parameter int unsigned NREG   = reg_fetch_block_pkg::NREG
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_en,
   input  logic [2:0]        wb_addr,
   input  logic [DATA_W-1:0] ans_wb,
   input  logic              id_valid,
   input  logic [2:0]        rs_addr,
   input  logic [2:0]        rt_addr,
   input  logic [2:0]        rd_addr,
   input  logic              rd_write,
   output logic              id_ready,
   input  logic              ex_ready,
   output logic              of_valid,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [2:0]        of_rd_addr,
   output logic              of_rd_write
);
   import reg_fetch_block_pkg::*;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];

   logic              of_valid_q, of_valid_d;
   logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
   logic [2:0]        of_rd_addr_q, of_rd_addr_d;
   logic              of_rd_write_q, of_rd_write_d;

   logic              wb_live, hazard, accept;
   logic [DATA_W-1:0] rd_a, rd_b;

   assign wb_live = wb_en && (wb_addr != REG_ZERO);

   assign rd_a = (rs_addr == REG_ZERO)          ? '0     :
                 (wb_live && wb_addr == rs_addr) ? ans_wb : regs_q[rs_addr];
   assign rd_b = (rt_addr == REG_ZERO)          ? '0     :
                 (wb_live && wb_addr == rt_addr) ? ans_wb : regs_q[rt_addr];

   reg_scoreboard #(.NREG(NREG)) u_sb (
      .clk         (clk),
      .reset       (reset),
      .set_en_i    (accept && rd_write),
      .set_addr_i  (rd_addr),
      .clr_en_i    (wb_en),
      .clr_addr_i  (wb_addr),
      .chk_valid_i (id_valid),
      .rs_addr_i   (rs_addr),
      .rt_addr_i   (rt_addr),
      .rd_addr_i   (rd_addr),
      .rd_write_i  (rd_write),
      .hazard_o    (hazard)
   );

   assign id_ready = !reset && (!of_valid_q || ex_ready) && !hazard;
   assign accept   = id_valid && id_ready;

   always_comb begin
      regs_d = regs_q;
      if (wb_live) regs_d[wb_addr] = ans_wb;
   end

   always_comb begin
      of_valid_d    = of_valid_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      of_rd_addr_d  = of_rd_addr_q;
      of_rd_write_d = of_rd_write_q;
      if (accept) begin
         of_valid_d    = 1'b1;
         op_a_d        = rd_a;
         op_b_d        = rd_b;
         of_rd_addr_d  = rd_addr;
         of_rd_write_d = rd_write;
      end else if (ex_ready) begin
         of_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q        <= '{default: '0};
         of_valid_q    <= 1'b0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         of_rd_addr_q  <= '0;
         of_rd_write_q <= 1'b0;
      end else begin
         regs_q        <= regs_d;
         of_valid_q    <= of_valid_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         of_rd_addr_q  <= of_rd_addr_d;
         of_rd_write_q <= of_rd_write_d;
      end
   end

   assign of_valid    = of_valid_q;
   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign of_rd_addr  = of_rd_addr_q;
   assign of_rd_write = of_rd_write_q;

endmodule

// File: tb/tb_reg_fetch_block.sv
// Directed scenarios plus random traffic checked against an array-based model of the fetch stage.
module tb_reg_fetch_block;

   logic       clk = 1'b0;
   logic       reset, wb_en, id_valid, rd_write, ex_ready;
   logic [2:0] wb_addr, rs_addr, rt_addr, rd_addr;
   logic [7:0] ans_wb;
   logic       id_ready, of_valid, of_rd_write;
   logic [7:0] op_a, op_b;
   logic [2:0] of_rd_addr;

   always #5 clk = ~clk;

   reg_fetch_block #(.DATA_W(8), .NREG(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .ans_wb      (ans_wb),
      .id_valid    (id_valid),
      .rs_addr     (rs_addr),
      .rt_addr     (rt_addr),
      .rd_addr     (rd_addr),
      .rd_write    (rd_write),
      .id_ready    (id_ready),
      .ex_ready    (ex_ready),
      .of_valid    (of_valid),
      .op_a        (op_a),
      .op_b        (op_b),
      .of_rd_addr  (of_rd_addr),
      .of_rd_write (of_rd_write)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model state
   logic [7:0] m_reg [8];
   bit         m_busy [8];
   bit         m_ov, m_orw;
   logic [7:0] m_oa, m_ob;
   logic [2:0] m_ord;

   function automatic logic [7:0] m_read(input logic [2:0] x);
      if (x == 3'd0) return 8'h00;
      if (wb_en && wb_addr == x) return ans_wb;
      return m_reg[x];
   endfunction

   function automatic bit m_pend(input logic [2:0] x);
      return m_busy[x] && !(wb_en && wb_addr == x);
   endfunction

   task automatic cycle();
      bit haz, rdy, acc;
      logic [7:0] na, nb;
      #1;
      haz = id_valid && (m_pend(rs_addr) || m_pend(rt_addr) || (rd_write && m_pend(rd_addr)));
      rdy = !reset && (!m_ov || ex_ready) && !haz;
      acc = id_valid && rdy;
      check_val("id_ready", {31'd0, id_ready}, {31'd0, rdy});
      na = m_read(rs_addr);
      nb = m_read(rt_addr);
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            m_reg[i]  = 8'h00;
            m_busy[i] = 1'b0;
         end
         m_ov = 0; m_orw = 0; m_oa = 0; m_ob = 0; m_ord = 0;
      end else begin
         if (wb_en && wb_addr != 3'd0) m_reg[wb_addr] = ans_wb;
         if (wb_en) m_busy[wb_addr] = 1'b0;
         if (acc && rd_write && rd_addr != 3'd0) m_busy[rd_addr] = 1'b1;
         if (acc) begin
            m_ov = 1; m_oa = na; m_ob = nb; m_ord = rd_addr; m_orw = rd_write;
         end else if (ex_ready) begin
            m_ov = 0;
         end
      end
      #1;
      check_val("of_valid",    {31'd0, of_valid},    {31'd0, m_ov});
      check_val("op_a",        {24'd0, op_a},        {24'd0, m_oa});
      check_val("op_b",        {24'd0, op_b},        {24'd0, m_ob});
      check_val("of_rd_addr",  {29'd0, of_rd_addr},  {29'd0, m_ord});
      check_val("of_rd_write", {31'd0, of_rd_write}, {31'd0, m_orw});
   endtask

   task automatic idle();
      reset = 0; wb_en = 0; wb_addr = 0; ans_wb = 0;
      id_valid = 0; rs_addr = 0; rt_addr = 0; rd_addr = 0; rd_write = 0;
      ex_ready = 1;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         m_reg[i] = 8'h00; m_busy[i] = 1'b0;
      end
      m_ov = 0; m_orw = 0; m_oa = 0; m_ob = 0; m_ord = 0;

      // Reset with noisy inputs that must be ignored
      idle(); reset = 1; wb_en = 1; wb_addr = 3'd1; ans_wb = 8'hEE; id_valid = 1;
      cycle(); cycle();
      check_val("rst_valid", {31'd0, of_valid}, 32'd0);
      check_val("rst_op_a",  {24'd0, op_a},     32'd0);

      // Write-back then read
      idle(); wb_en = 1; wb_addr = 3'd3; ans_wb = 8'h5A; cycle();
      idle(); id_valid = 1; rs_addr = 3'd3; rt_addr = 3'd0; cycle();
      check_val("r22_valid", {31'd0, of_valid}, 32'd1);
      check_val("r22_op_a",  {24'd0, op_a},     32'h5A);
      check_val("r22_op_b",  {24'd0, op_b},     32'h00);

      // Same-cycle bypass
      idle(); wb_en = 1; wb_addr = 3'd2; ans_wb = 8'hC3;
      id_valid = 1; rs_addr = 3'd2; rt_addr = 3'd3; cycle();
      check_val("r23_op_a", {24'd0, op_a}, 32'hC3);
      check_val("r23_op_b", {24'd0, op_b}, 32'h5A);

      // RAW hazard on R4 until write-back
      idle(); id_valid = 1; rd_addr = 3'd4; rd_write = 1; cycle();
      check_val("r24_rd", {29'd0, of_rd_addr}, 32'd4);
      idle(); id_valid = 1; rs_addr = 3'd4;
      repeat (3) begin
         #1 check_val("r24_stall", {31'd0, id_ready}, 32'd0);
         cycle();
      end
      wb_en = 1; wb_addr = 3'd4; ans_wb = 8'h11;
      #1 check_val("r24_release", {31'd0, id_ready}, 32'd1);
      cycle();
      check_val("r24_op_a", {24'd0, op_a}, 32'h11);

      // Back-pressure from execute
      idle(); id_valid = 1; rs_addr = 3'd3; rt_addr = 3'd2; rd_addr = 3'd6; cycle();
      idle(); ex_ready = 0; id_valid = 1; rs_addr = 3'd1; rt_addr = 3'd4; rd_addr = 3'd7;
      repeat (3) begin
         #1 check_val("r25_stall", {31'd0, id_ready}, 32'd0);
         cycle();
         check_val("r25_hold_a",  {24'd0, op_a},       32'h5A);
         check_val("r25_hold_b",  {24'd0, op_b},       32'hC3);
         check_val("r25_hold_rd", {29'd0, of_rd_addr}, 32'd6);
      end
      ex_ready = 1;
      #1 check_val("r25_go", {31'd0, id_ready}, 32'd1);
      cycle();
      check_val("r25_new_b",  {24'd0, op_b},       32'h11);
      check_val("r25_new_rd", {29'd0, of_rd_addr}, 32'd7);

      // R0 is hardwired, reset drops busy bits
      idle(); wb_en = 1; wb_addr = 3'd0; ans_wb = 8'hFF; cycle();
      idle(); id_valid = 1; rs_addr = 3'd0; rt_addr = 3'd0; cycle();
      check_val("r26_r0", {24'd0, op_a}, 32'h00);
      idle(); id_valid = 1; rd_addr = 3'd5; rd_write = 1; cycle();
      idle(); reset = 1; cycle();
      check_val("r26_rst_valid", {31'd0, of_valid}, 32'd0);
      idle(); id_valid = 1; rs_addr = 3'd5;
      #1 check_val("r26_ready", {31'd0, id_ready}, 32'd1);
      cycle();
      check_val("r26_valid", {31'd0, of_valid}, 32'd1);

      // Random traffic
      repeat (800) begin
         reset    = ($urandom_range(0, 99) == 0);
         wb_en    = ($urandom_range(0, 2) == 0);
         wb_addr  = 3'($urandom_range(0, 7));
         ans_wb   = 8'($urandom);
         id_valid = ($urandom_range(0, 3) != 0);
         rs_addr  = 3'($urandom_range(0, 7));
         rt_addr  = 3'($urandom_range(0, 7));
         rd_addr  = 3'($urandom_range(0, 7));
         rd_write = ($urandom_range(0, 1) == 1);
         ex_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
